// File: rtl/ofuf_pkg.sv
// Shared constants for the timer wrap monitor: direction encoding, default widths
// and the bit positions used when the flags are packed into a status register.
package ofuf_pkg;

   localparam logic OFUF_UP = 1'b1;
   localparam logic OFUF_DN = 1'b0;

   localparam int OFUF_CNT_W = 8;
   localparam int OFUF_EVT_W = 4;

   localparam int OFUF_IDX_OF = 0;
   localparam int OFUF_IDX_UF = 1;

endpackage : ofuf_pkg

// File: rtl/ofuf_chan.sv
// One event channel: registered pulse, sticky flag and saturating counter.
// All outputs update on the edge that samples evt; no flow control, always accepts.
module ofuf_chan
   import ofuf_pkg::*;
#(
   parameter int EVT_W = OFUF_EVT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             evt,
   input  logic             clr,
   output logic             pls,
   output logic             flag,
   output logic [EVT_W-1:0] evt_cnt
);

   localparam logic [EVT_W-1:0] CNT_SAT = '1;

   logic             pls_q, pls_d;
   logic             flag_q, flag_d;
   logic [EVT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      pls_d  = evt;
      // A coincident event beats the clear so no wrap is ever silently lost.
      flag_d = evt | (flag_q & ~clr);
      cnt_d  = cnt_q;
      if (clr) begin
         cnt_d = evt ? {{(EVT_W-1){1'b0}}, 1'b1} : '0;
      end else if (evt && (cnt_q != CNT_SAT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pls_q  <= 1'b0;
         flag_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         pls_q  <= pls_d;
         flag_q <= flag_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pls     = pls_q;
   assign flag    = flag_q;
   assign evt_cnt = cnt_q;

endmodule : ofuf_chan

// File: rtl/ofuf_monitor.sv
// Timer wrap monitor: detects MAX->0 (up) and 0->MAX (down) between qualified samples, one-cycle latency.
// OFUF_MONITOR_IRQ_EN adds of_ie/uf_ie and a registered level irq; no backpressure.
module ofuf_monitor
   import ofuf_pkg::*;
#(
   parameter int CNT_W = OFUF_CNT_W,
   parameter int EVT_W = OFUF_EVT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] cnt,
   input  logic             cnt_vld,
   input  logic             up_dn,
   input  logic             cnt_ld,
   input  logic             clr_of,
   input  logic             clr_uf,
   output logic             of,
   output logic             uf,
   output logic             of_pls,
   output logic             uf_pls,
   output logic [EVT_W-1:0] of_cnt,
`ifdef OFUF_MONITOR_IRQ_EN
   input  logic             of_ie,
   input  logic             uf_ie,
   output logic             irq,
`endif
   output logic [EVT_W-1:0] uf_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] prev_q, prev_d;
   logic             prev_vld_q, prev_vld_d;
   logic             step_ok;
   logic             of_evt, uf_evt;

   // A load or the first sample after reset only establishes the baseline.
   assign step_ok = cnt_vld & prev_vld_q & ~cnt_ld;
   assign of_evt  = step_ok & (up_dn == OFUF_UP) & (prev_q == CNT_MAX) & (cnt == '0);
   assign uf_evt  = step_ok & (up_dn == OFUF_DN) & (prev_q == '0) & (cnt == CNT_MAX);

   always_comb begin
      prev_d     = prev_q;
      prev_vld_d = prev_vld_q;
      if (cnt_vld) begin
         prev_d     = cnt;
         prev_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         prev_vld_q <= prev_vld_d;
      end
   end

   ofuf_chan #(.EVT_W(EVT_W)) u_of_chan (
      .clk     (clk),
      .rst     (rst),
      .evt     (of_evt),
      .clr     (clr_of),
      .pls     (of_pls),
      .flag    (of),
      .evt_cnt (of_cnt)
   );

   ofuf_chan #(.EVT_W(EVT_W)) u_uf_chan (
      .clk     (clk),
      .rst     (rst),
      .evt     (uf_evt),
      .clr     (clr_uf),
      .pls     (uf_pls),
      .flag    (uf),
      .evt_cnt (uf_cnt)
   );

`ifdef OFUF_MONITOR_IRQ_EN
   logic irq_q, irq_d;

   // Built from the registered flags, so irq trails a flag or enable change by one cycle.
   assign irq_d = (of & of_ie) | (uf & uf_ie);

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq = irq_q;
`endif

endmodule : ofuf_monitor
